// File: rtl/latch_gate_sequencer.sv
// Round-robin sequencer sharing one transparent latch: setup / gate-open / hold timing.
// Optional macro LATCH_READBACK_EN adds q_in readback and a sticky rb_err flag.
module latch_gate_sequencer #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] din,
`ifdef LATCH_READBACK_EN
  input  logic [WIDTH-1:0]       q_in,
  output logic                   rb_err,
`endif
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       D_out,
  output logic                   G_out,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             state_dbg
);

  // Handshake: req is a level request; the matching gnt bit stays high from the
  // grant edge through the last HOLD cycle, and done marks that last cycle.
  localparam int MAX_CYC = (SETUP_CYC > OPEN_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((OPEN_CYC > HOLD_CYC) ? OPEN_CYC : HOLD_CYC);
  localparam int CNT_W = $clog2(MAX_CYC + 1);
  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [PTR_W-1:0]   idx_q, idx_d;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;

  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]   d_out_q, d_out_d;
  logic               g_q, g_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
    end
  end

  // Round-robin search upward from rr_q, wrapping at N_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((int'(rr_q) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (win_found) begin
          state_d = SETUP;
          idx_d   = win_idx;
        end
      end
      SETUP: begin
        if (int'(cnt_q) == SETUP_CYC - 1) begin
          state_d = OPEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OPEN: begin
        if (int'(cnt_q) == OPEN_CYC - 1) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (int'(cnt_q) == HOLD_CYC - 1) begin
          state_d = IDLE;
          cnt_d   = '0;
          rr_d    = (int'(idx_q) == N_REQ - 1) ? '0 : idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output is a flop.
  always_comb begin
    gnt_d   = '0;
    d_out_d = d_out_q;
    if (state_d != IDLE) gnt_d[idx_d] = 1'b1;
    if (state_q == IDLE && win_found) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (int'(win_idx) == i) d_out_d = din[i*WIDTH +: WIDTH];
      end
    end
    g_d    = (state_d == OPEN);
    busy_d = (state_d != IDLE);
    done_d = (state_d == HOLD) && (int'(cnt_d) == HOLD_CYC - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      d_out_q <= '0;
      g_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      d_out_q <= d_out_d;
      g_q     <= g_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef LATCH_READBACK_EN
  logic rb_err_q, rb_err_d;

  // Latch Q is compared once, in the first HOLD cycle after the gate has closed.
  always_comb begin
    rb_err_d = rb_err_q;
    if (state_q == HOLD && cnt_q == '0 && q_in != d_out_q) rb_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rb_err_q <= 1'b0;
    else        rb_err_q <= rb_err_d;
  end

  assign rb_err = rb_err_q;
`endif

  assign gnt       = gnt_q;
  assign D_out     = d_out_q;
  assign G_out     = g_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_latch_gate_sequencer.sv
// Bench for latch_gate_sequencer: transaction-position model, per-cycle compare, directed pins.
module tb_latch_gate_sequencer;
  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 1;
  localparam int O = 2;
  localparam int H = 1;
  localparam int L = S + O + H;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic [W-1:0]   D_out;
  logic           G_out;
  logic           busy;
  logic           done;
  logic [1:0]     state_dbg;

  int n_checks = 0;
  int n_errors = 0;

`ifdef LATCH_READBACK_EN
  logic [W-1:0] q_lat = '0;
  logic         q_force = 1'b0;
  logic [W-1:0] q_in;
  logic         rb_err;
  always @* if (G_out) q_lat = D_out;
  assign q_in = q_force ? '0 : q_lat;
`endif

  latch_gate_sequencer #(
    .N_REQ(N), .WIDTH(W), .SETUP_CYC(S), .OPEN_CYC(O), .HOLD_CYC(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
`ifdef LATCH_READBACK_EN
    .q_in(q_in), .rb_err(rb_err),
`endif
    .gnt(gnt), .D_out(D_out), .G_out(G_out), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_t is the position inside a transaction (0 = idle, 1..L = busy cycles).
  int           m_t, m_idx, m_rr;
  logic [W-1:0] m_data;
  logic         m_rb;

  function automatic int pick(input logic [N-1:0] r, input int rr);
    for (int k = 0; k < N; k++) begin
      if (r[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_idx <= 0; m_rr <= 0; m_data <= '0; m_rb <= 1'b0;
    end else begin
`ifdef LATCH_READBACK_EN
      if (m_t == S + O + 1 && q_in != m_data) m_rb <= 1'b1;
`endif
      if (m_t == 0) begin
        if (pick(req, m_rr) >= 0) begin
          m_idx  <= pick(req, m_rr);
          m_data <= W'(din >> (pick(req, m_rr) * W));
          m_t    <= 1;
        end
      end else if (m_t == L) begin
        m_t  <= 0;
        m_rr <= (m_idx + 1) % N;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("gnt",   32'(gnt),   (m_t != 0) ? (32'd1 << m_idx) : 32'd0);
    chk("d_out", 32'(D_out), 32'(m_data));
    chk("g_out", 32'(G_out), 32'(m_t > S && m_t <= S + O));
    chk("busy",  32'(busy),  32'(m_t != 0));
    chk("done",  32'(done),  32'(m_t == L));
`ifdef LATCH_READBACK_EN
    chk("rb_err", 32'(rb_err), 32'(m_rb));
`endif
  end

  task automatic do_reset();
    @(negedge clk);
    req   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [N-1:0] exp_g [5];
  int           g_cnt, last_cyc;
  logic         prev_busy, open_seen;

  initial begin
    rst_n = 1'b0;
    req   = '1;
    din   = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt",  32'(gnt),   32'h0);
    chk("rst_g",    32'(G_out), 32'h0);
    chk("rst_busy", 32'(busy),  32'h0);
    chk("rst_done", 32'(done),  32'h0);
    chk("rst_d",    32'(D_out), 32'h0);
    req   = '0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", 32'(busy),  32'h0);
    chk("idle_gnt",  32'(gnt),   32'h0);
    chk("idle_d",    32'(D_out), 32'h0);

    // Single request on slot 2, then data/req change during OPEN.
    din = {8'h11, 8'hA5, 8'h22, 8'h33};
    req = 4'b0100;
    @(negedge clk);
    chk("single_gnt",  32'(gnt),   32'h4);
    chk("single_d",    32'(D_out), 32'hA5);
    chk("single_busy", 32'(busy),  32'h1);
    chk("single_g_c1", 32'(G_out), 32'h0);
    @(negedge clk);
    chk("single_g_c2", 32'(G_out), 32'h1);
    din[2*W +: W] = 8'h3C;
    req = '0;
    @(negedge clk);
    chk("single_g_c3", 32'(G_out), 32'h1);
    chk("iso_d_c3",    32'(D_out), 32'hA5);
    @(negedge clk);
    chk("single_done", 32'(done),  32'h1);
    chk("single_g_c4", 32'(G_out), 32'h0);
    chk("iso_d_c4",    32'(D_out), 32'hA5);
    @(negedge clk);
    chk("single_c5_gnt",  32'(gnt),  32'h0);
    chk("single_c5_busy", 32'(busy), 32'h0);

    // Fairness from reset with all requests held.
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req       = '1;
    g_cnt     = 0;
    last_cyc  = 0;
    prev_busy = 1'b0;
    for (int cyc = 0; cyc < 100 && g_cnt < 5; cyc++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        chk("fair_gnt", 32'(gnt), 32'(exp_g[g_cnt]));
        if (g_cnt > 0) chk("fair_gap", 32'(cyc - last_cyc), 32'(L + 1));
        last_cyc = cyc;
        g_cnt++;
      end
      prev_busy = busy;
    end
    chk("fair_count", 32'(g_cnt), 32'd5);

    // Asynchronous reset while the gate is open.
    open_seen = 1'b0;
    for (int cyc = 0; cyc < 20 && !open_seen; cyc++) begin
      @(negedge clk);
      open_seen = G_out;
    end
    chk("async_open_seen", 32'(open_seen), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_g",    32'(G_out), 32'h0);
    chk("async_gnt",  32'(gnt),   32'h0);
    chk("async_busy", 32'(busy),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = '1;
    @(negedge clk);
    chk("async_first_gnt", 32'(gnt), 32'h1);

    // Random traffic checked cycle by cycle against the model.
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      for (int i = 0; i < N; i++) din[i*W +: W] = W'($urandom);
    end

`ifdef LATCH_READBACK_EN
    do_reset();
    chk("rb_clear", 32'(rb_err), 32'h0);
    q_force = 1'b1;
    din[2*W +: W] = 8'hA5;
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    chk("rb_before_edge", 32'(rb_err), 32'h0);
    @(negedge clk);
    chk("rb_set", 32'(rb_err), 32'h1);
    q_force = 1'b0;
    repeat (5) @(negedge clk);
    chk("rb_sticky", 32'(rb_err), 32'h1);
    do_reset();
    @(negedge clk);
    chk("rb_reset", 32'(rb_err), 32'h0);
`endif

    req = '0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
